// File: rtl/adder_tree_seq_sched.sv
// adder_tree_seq_sched: reduces a frame of NUM_OPERANDS unsigned operands, streamed
// one per cycle through a single adder, into one sum with valid/ready on both sides.
// Ports: clk, rst (async, active-high), clear (sync abort of partial frame / pending sum),
//   in_valid/in_ready/in_data (operand stream), out_valid/out_ready/out_sum (frame sum),
//   busy (frame in progress or result pending).
// Option: define ADDER_SEQ_SCHED_PIPE_EN to register the operand ahead of the adder;
//   adds state PEND and one extra cycle of latency.
module adder_tree_seq_sched #(
    parameter int ADDER_WIDTH = 9,
    parameter int NUM_OPERANDS = 8,
    localparam int SUM_WIDTH = ADDER_WIDTH + $clog2(NUM_OPERANDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_WIDTH-1:0]   out_sum,
    output logic                   busy
);
    localparam int CW = $clog2(NUM_OPERANDS);
    localparam logic [1:0] ACC  = 2'd0;
    localparam logic [1:0] OUT  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;
    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] sum;
    logic                 accept;
    logic                 last;
    assign in_ready  = (state == ACC) && !clear;
    assign out_valid = (state == OUT);
    assign busy      = (cnt != '0) || (state != ACC);
    assign accept    = in_valid && in_ready;
    assign last      = cnt == CW'(NUM_OPERANDS - 1);
`ifdef ADDER_SEQ_SCHED_PIPE_EN
    logic [ADDER_WIDTH-1:0] op_q;
    logic                   op_v;
    logic                   op_first;
    logic                   op_last;
    // The first/last flags travel with the staged operand so the adder needs no counter.
    assign sum = (op_first ? '0 : acc) + SUM_WIDTH'(op_q);
`else
    // The first beat of a frame starts from zero, so acc never needs an explicit clear.
    assign sum = (cnt == '0 ? '0 : acc) + SUM_WIDTH'(in_data);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACC;
            cnt     <= '0;
            acc     <= '0;
            out_sum <= '0;
`ifdef ADDER_SEQ_SCHED_PIPE_EN
            op_q     <= '0;
            op_v     <= 1'b0;
            op_first <= 1'b0;
            op_last  <= 1'b0;
`endif
        end else if (clear) begin
            state <= ACC;
            cnt   <= '0;
`ifdef ADDER_SEQ_SCHED_PIPE_EN
            op_v  <= 1'b0;
`endif
        end else begin
`ifdef ADDER_SEQ_SCHED_PIPE_EN
            op_v <= accept;
            if (accept) begin
                op_q     <= in_data;
                op_first <= cnt == '0;
                op_last  <= last;
                cnt      <= last ? '0 : cnt + CW'(1);
                if (last)
                    state <= PEND;
            end
            if (op_v) begin
                acc <= sum;
                if (op_last) begin
                    out_sum <= sum;
                    state   <= OUT;
                end
            end
`else
            if (accept) begin
                acc <= sum;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    out_sum <= sum;
                    state   <= OUT;
                end
            end
`endif
            if (state == OUT && out_ready)
                state <= ACC;
        end
    end
endmodule

// File: tb/tb_adder_tree_seq_sched.sv
// tb_adder_tree_seq_sched: randomized and directed bench for adder_tree_seq_sched with a
// frame-level reference model checked every cycle.
module tb_adder_tree_seq_sched;
`ifdef ADDER_SEQ_SCHED_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 1;
    logic [8:0] in_data = '0;
    logic in_ready, out_valid, busy;
    logic [11:0] out_sum;
    logic clear5 = 0, in5_valid = 0, out5_ready = 1;
    logic [8:0] in5_data = '0;
    logic in5_ready, out5_valid, busy5;
    logic [11:0] out5_sum;
    int checks = 0, errors = 0;
    int ops[$];
    bit holding = 0, m_valid = 0;
    int wait_n = 0, pend = 0;
    logic [31:0] m_sum = '0;

    adder_tree_seq_sched #(.ADDER_WIDTH(9), .NUM_OPERANDS(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .busy(busy));
    adder_tree_seq_sched #(.ADDER_WIDTH(9), .NUM_OPERANDS(5)) dut5 (
        .clk(clk), .rst(rst), .clear(clear5), .in_valid(in5_valid), .in_ready(in5_ready),
        .in_data(in5_data), .out_valid(out5_valid), .out_ready(out5_ready), .out_sum(out5_sum),
        .busy(busy5));

    initial forever #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Frame-level model: collect accepted operands, publish their sum LAT edges after the last.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            ops.delete(); holding = 0; m_valid = 0; wait_n = 0; m_sum = '0;
        end else if (clear) begin
            ops.delete(); holding = 0; m_valid = 0; wait_n = 0;
        end else begin
            automatic bit acc_m = in_valid && !holding;
            if (m_valid && out_ready) begin m_valid = 0; holding = 0; end
            if (acc_m) begin
                ops.push_back(int'(in_data));
                if (ops.size() == 8) begin
                    pend = 0;
                    foreach (ops[i]) pend += ops[i];
                    ops.delete(); holding = 1; wait_n = LAT;
                end
            end
            if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) begin m_valid = 1; m_sum = 32'(pend); end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!holding && !clear));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_sum", 32'(out_sum), m_sum);
        check("busy", 32'(busy), 32'(ops.size() != 0 || holding));
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic beat(input int v);
        bit ok = 0;
        in_valid = 1; in_data = 9'(v);
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk); ok = in_ready; tick();
        end
        in_valid = 0;
        if (!ok) begin checks++; errors++; $display("FAIL beat_timeout: got no accept for %0d", v); end
    endtask

    task automatic wait_out(input string n, input int exp);
        int k = 1;
        @(negedge clk);
        while (!out_valid && k < 40) begin k++; @(negedge clk); end
        check({n, "_lat"}, 32'(k), 32'(LAT));
        check({n, "_sum"}, 32'(out_sum), 32'(exp));
        tick();
    endtask

    initial begin
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_busy", 32'(busy), 0);
        tick(); rst = 0; tick();
        // T1
        repeat (8) beat(511);
        wait_out("t1", 4088);
        @(negedge clk); check("t1_one_cycle", 32'(out_valid), 0); tick();
        // T2
        for (int v = 1; v <= 8; v++) begin
            repeat ($urandom_range(0, 3)) tick();
            beat(v);
        end
        wait_out("t2", 36);
        // T3
        out_ready = 0;
        for (int v = 1; v <= 8; v++) beat(v);
        wait_out("t3", 36);
        in_valid = 1; in_data = 9'd99;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_sum", 32'(out_sum), 36);
            check("t3_hold_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1;
        beat(99);
        repeat (7) beat(1);
        wait_out("t3b", 106);
        // T4
        beat(10); beat(20); beat(30);
        clear = 1; in_valid = 1; in_data = 9'd77;
        @(negedge clk); check("t4_ready_clear", 32'(in_ready), 0);
        tick(); clear = 0; in_valid = 0;
        @(negedge clk); check("t4_busy_after_clear", 32'(busy), 0); tick();
        repeat (8) beat(1);
        wait_out("t4", 8);
        // T5
        repeat (5) beat(2);
        rst = 1; #1;
        check("t5_mid_valid", 32'(out_valid), 0);
        check("t5_mid_busy", 32'(busy), 0);
        check("t5_mid_sum", 32'(out_sum), 0);
        tick(); rst = 0; out_ready = 0;
        repeat (8) beat(2);
        wait_out("t5a", 16);
        rst = 1; #1;
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_out_sum", 32'(out_sum), 0);
        check("t5_out_ready", 32'(in_ready), 1);
        tick(); rst = 0; out_ready = 1;
        repeat (8) beat(2);
        wait_out("t5b", 16);
        // T6
        in5_valid = 1; in5_data = 9'd511;
        repeat (5) begin @(negedge clk); check("t6_ready", 32'(in5_ready), 1); tick(); end
        in5_valid = 0;
        begin
            int k = 1;
            @(negedge clk);
            while (!out5_valid && k < 40) begin k++; @(negedge clk); end
            check("t6_lat", 32'(k), 32'(LAT));
            check("t6_sum", 32'(out5_sum), 2555);
            tick();
        end
        // Random traffic, model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom % 3) != 0;
            in_data = 9'($urandom_range(0, 511));
            out_ready = ($urandom % 4) != 0;
            clear = ($urandom % 64) == 0;
            tick();
        end
        in_valid = 0; clear = 0; out_ready = 1;
        repeat (10) tick();
        check("t6_busy_end", 32'(busy5), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
